// File: rtl/spi_master_p.sv
`timescale 1ns/1ps
// spi_master_p -- parametrised SPI mode-0 master in a single clk domain.
// Each transfer shifts one receiver word (or all-ones fill) out on mosi and
// captures one miso word for the transmitter. sck is a registered output
// produced by a clock-enable divider; it is never used as a clock.
// Build option: define SPIM_RX_SKID_EN to add a one-entry rx holding buffer
// so a receiver word can be accepted while a transfer is in flight.
module spi_master_p #(
    parameter int WIDTH     = 16,
    parameter int DIV       = 1,
    parameter int GAP       = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_strobe,
    output logic             rx_accept,
    input  logic             tx_request,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_strobe,
    output logic             busy,
    output logic             ss,
    output logic             sck,
    output logic             mosi,
    input  logic             miso
);

    localparam int GAP_CYC = 2 * GAP * DIV;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W   = $clog2(GAP_CYC);
    localparam int BIT_W   = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_END} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] rx_word;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             tx_pend;
    logic             rx_avail;
    logic             rx_take;
    logic             start_now;

    // Bit that goes on the wire first for a given word
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Shift helpers: advance the outgoing word and fold miso into the capture in wire order
    always_comb begin
        if (MSB_FIRST) begin
            shreg_next = {shreg[WIDTH-2:0], 1'b1};
            cap_next   = {capture[WIDTH-2:0], miso};
        end else begin
            shreg_next = {1'b1, shreg[WIDTH-1:1]};
            cap_next   = {miso, capture[WIDTH-1:1]};
        end
        load_word = rx_avail ? rx_word : '1;
    end

`ifdef SPIM_RX_SKID_EN
    logic             skid_full;
    logic [WIDTH-1:0] skid_data;
    logic             fresh_rx;
    logic             direct_take;
    logic             skid_load;

    // rx source selection; a strobe already acknowledged by the live rx_accept pulse is not new
    always_comb begin
        fresh_rx    = rx_strobe && !rx_accept;
        rx_avail    = skid_full || fresh_rx;
        rx_word     = skid_full ? skid_data : rx_data;
        start_now   = (state == S_IDLE) && (rx_avail || tx_request);
        direct_take = start_now && !skid_full && fresh_rx;
        skid_load   = fresh_rx && !direct_take && (!skid_full || start_now);
        rx_take     = direct_take || skid_load;
    end

    // Holding buffer: filled on accept in any state, emptied when IDLE starts from it
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (skid_load) begin
            skid_full <= 1'b1;
            skid_data <= rx_data;
        end else if (start_now && skid_full) begin
            skid_full <= 1'b0;
        end
    end
`else
    // rx source selection; without a buffer a word is only taken when IDLE starts
    always_comb begin
        rx_avail  = rx_strobe;
        rx_word   = rx_data;
        start_now = (state == S_IDLE) && (rx_avail || tx_request);
        rx_take   = start_now && rx_avail;
    end
`endif

    // Transfer FSM with registered SPI pins, strobes and busy
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ss        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b1;
            rx_accept <= 1'b0;
            tx_strobe <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            tx_pend   <= 1'b0;
            shreg     <= '1;
            capture   <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            rx_accept <= rx_take;
            case (state)
                S_IDLE: begin
                    if (start_now) begin
                        shreg   <= load_word;
                        mosi    <= first_bit(load_word);
                        ss      <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        tx_pend <= tx_request;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_W'(DIV - 1)) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (!sck) begin
                            capture <= cap_next;
                        end else if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                            ss      <= 1'b1;
                            mosi    <= 1'b1;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                            if (tx_pend) begin
                                tx_data   <= capture;
                                tx_strobe <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= shreg_next;
                            mosi    <= first_bit(shreg_next);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    // END and the IDLE sampling cycle add to ss-high time, so the
                    // start-to-start interval lands on 2*DIV*(WIDTH+GAP)+1 cycles
                    if (gap_cnt == GAP_W'(GAP_CYC - 2)) begin
                        state <= S_END;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_END: begin
                    if (!tx_request || !tx_strobe) begin
                        tx_strobe <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_p.sv
`timescale 1ns/1ps
// tb_spi_master_p -- bench for spi_master_p.
// Instance 0: WIDTH=16, DIV=1, GAP=2, LSB first. Instance 1: WIDTH=16, DIV=3,
// GAP=2, MSB first. A slave model on each bus serves miso from a word and
// reassembles the mosi bits into a word; expected values come from the words
// the bench itself chose.
module tb_spi_master_p;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] rx_data_w [2];
    logic [W-1:0] tx_data_w [2];
    logic         rx_strobe_w [2];
    logic         rx_accept_w [2];
    logic         tx_request_w [2];
    logic         tx_strobe_w [2];
    logic         busy_w [2];
    logic         ss_w [2];
    logic         sck_w [2];
    logic         mosi_w [2];
    logic         miso_w [2] = '{1'b0, 1'b0};

    // slave model / monitor state
    logic [W-1:0] slave_word [2] = '{16'h0, 16'h0};
    logic [W-1:0] cur_mosi   [2] = '{16'h0, 16'h0};
    logic [W-1:0] last_mosi  [2] = '{16'h0, 16'h0};
    logic [W-1:0] prev_mosi  [2] = '{16'h0, 16'h0};
    logic [W-1:0] last_txd   [2] = '{16'h0, 16'h0};
    logic         last_txs   [2] = '{1'b0, 1'b0};
    logic         prev_ss    [2] = '{1'b1, 1'b1};
    logic         prev_sck   [2] = '{1'b0, 1'b0};
    int           rise_cnt   [2] = '{0, 0};
    int           low_cyc    [2] = '{0, 0};
    int           hi_cyc     [2] = '{0, 0};
    int           sck_hi     [2] = '{0, 0};
    int           done_cnt   [2] = '{0, 0};
    int           acc_cnt    [2] = '{0, 0};
    int           last_low   [2] = '{0, 0};
    int           last_rises [2] = '{0, 0};
    int           last_gap   [2] = '{0, 0};
    int           last_hi    [2] = '{0, 0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_master_p #(.WIDTH(W), .DIV(1), .GAP(2), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .rx_data(rx_data_w[0]), .rx_strobe(rx_strobe_w[0]), .rx_accept(rx_accept_w[0]),
        .tx_request(tx_request_w[0]), .tx_data(tx_data_w[0]), .tx_strobe(tx_strobe_w[0]),
        .busy(busy_w[0]), .ss(ss_w[0]), .sck(sck_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0])
    );

    spi_master_p #(.WIDTH(W), .DIV(3), .GAP(2), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .rx_data(rx_data_w[1]), .rx_strobe(rx_strobe_w[1]), .rx_accept(rx_accept_w[1]),
        .tx_request(tx_request_w[1]), .tx_data(tx_data_w[1]), .tx_strobe(tx_strobe_w[1]),
        .busy(busy_w[1]), .ss(ss_w[1]), .sck(sck_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1])
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // wire position of the k-th transmitted bit
    function automatic int bit_pos(input int i, input int k);
        return (i == 1) ? (W - 1 - k) : k;
    endfunction

    // Slave model: serve miso, collect mosi on sck rises, measure ss/sck timing
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rx_accept_w[i]) acc_cnt[i]++;
            if (prev_ss[i] && !ss_w[i]) begin
                rise_cnt[i] = 0;
                cur_mosi[i] = '0;
                low_cyc[i]  = 0;
                last_gap[i] = hi_cyc[i];
                miso_w[i]   = slave_word[i][bit_pos(i, 0)];
            end
            if (!ss_w[i]) begin
                low_cyc[i]++;
                if (!prev_sck[i] && sck_w[i]) begin
                    if (rise_cnt[i] < W) cur_mosi[i][bit_pos(i, rise_cnt[i])] = mosi_w[i];
                    rise_cnt[i]++;
                    if (rise_cnt[i] < W) miso_w[i] = slave_word[i][bit_pos(i, rise_cnt[i])];
                end
            end
            if (sck_w[i]) begin
                if (!prev_sck[i]) sck_hi[i] = 0;
                sck_hi[i]++;
            end
            if (prev_sck[i] && !sck_w[i]) last_hi[i] = sck_hi[i];
            if (!prev_ss[i] && ss_w[i]) begin
                done_cnt[i]++;
                prev_mosi[i]  = last_mosi[i];
                last_mosi[i]  = cur_mosi[i];
                last_low[i]   = low_cyc[i];
                last_rises[i] = rise_cnt[i];
                last_txs[i]   = tx_strobe_w[i];
                last_txd[i]   = tx_data_w[i];
                rise_cnt[i]   = 0;
                hi_cyc[i]     = 0;
            end
            if (ss_w[i]) hi_cyc[i]++;
            prev_ss[i]  = ss_w[i];
            prev_sck[i] = sck_w[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present a word and/or a tx request; an rx strobe is dropped once rx_accept is seen
    task automatic applyStimulus(input int i, input logic [W-1:0] word,
                                 input logic do_rx, input logic do_tx);
        int n;
        rx_data_w[i]    = word;
        tx_request_w[i] = do_tx;
        rx_strobe_w[i]  = do_rx;
        if (do_rx) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rx_accept_w[i] && n < 400);
            checkOutput("rx_accept_seen", rx_accept_w[i], 1);
            rx_strobe_w[i] = 1'b0;
        end
    endtask

    task automatic wait_done(input int i, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt[i] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("transfer_done", done_cnt[i] >= target, 1);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy_w[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("back_to_idle", busy_w[i], 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0, d1, a0, n, inst, mode;
        logic [W-1:0] w1, w2, rw, mw;

        for (int i = 0; i < 2; i++) begin
            rx_data_w[i]    = '0;
            rx_strobe_w[i]  = 1'b0;
            tx_request_w[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // reset values
        checkOutput("rst_ss", ss_w[0], 1);
        checkOutput("rst_sck", sck_w[0], 0);
        checkOutput("rst_mosi", mosi_w[0], 1);
        checkOutput("rst_rx_accept", rx_accept_w[0], 0);
        checkOutput("rst_tx_strobe", tx_strobe_w[0], 0);
        checkOutput("rst_tx_data", tx_data_w[0], 0);
        checkOutput("rst_busy", busy_w[0], 0);
        checkOutput("rst_ss1", ss_w[1], 1);
        checkOutput("rst_busy1", busy_w[1], 0);
        reset = 1'b0;
        @(negedge clk);

        // rx only, LSB first
        $display("[TB] rx only");
        a0 = acc_cnt[0];
        d0 = done_cnt[0];
        slave_word[0] = 16'($urandom);
        applyStimulus(0, 16'hA55A, 1'b1, 1'b0);
        wait_done(0, d0 + 1, 200);
        checkOutput("rx_mosi", last_mosi[0], 16'hA55A);
        checkOutput("rx_ss_low", last_low[0], 32);
        checkOutput("rx_rises", last_rises[0], 16);
        checkOutput("rx_accept_len", acc_cnt[0] - a0, 1);
        checkOutput("rx_tx_strobe", last_txs[0], 0);
        wait_idle(0);
        repeat (10) @(negedge clk);
        checkOutput("rx_single", done_cnt[0], d0 + 1);

        // tx only, held request
        $display("[TB] tx only");
        d0 = done_cnt[0];
        slave_word[0] = 16'h1234;
        applyStimulus(0, 16'h0000, 1'b0, 1'b1);
        wait_done(0, d0 + 1, 200);
        checkOutput("tx_mosi_fill", last_mosi[0], 16'hFFFF);
        checkOutput("tx_strobe_at_ss", last_txs[0], 1);
        checkOutput("tx_data_at_ss", last_txd[0], 16'h1234);
        repeat (30) @(negedge clk);
        checkOutput("tx_strobe_held", tx_strobe_w[0], 1);
        checkOutput("tx_data_held", tx_data_w[0], 16'h1234);
        checkOutput("tx_no_second", done_cnt[0], d0 + 1);
        checkOutput("tx_busy_held", busy_w[0], 1);
        tx_request_w[0] = 1'b0;
        wait_idle(0);
        checkOutput("tx_strobe_clr", tx_strobe_w[0], 0);
        repeat (20) @(negedge clk);
        checkOutput("tx_no_retrigger", done_cnt[0], d0 + 1);

        // MSB first, DIV=3, rx and tx starting together
        $display("[TB] msb first div 3");
        d1 = done_cnt[1];
        slave_word[1] = 16'hC003;
        applyStimulus(1, 16'h8001, 1'b1, 1'b1);
        wait_done(1, d1 + 1, 400);
        checkOutput("both_mosi", last_mosi[1], 16'h8001);
        checkOutput("both_ss_low", last_low[1], 96);
        checkOutput("both_sck_half", last_hi[1], 3);
        checkOutput("both_tx_strobe", last_txs[1], 1);
        checkOutput("both_tx_data", last_txd[1], 16'hC003);
        tx_request_w[1] = 1'b0;
        wait_idle(1);
        repeat (20) @(negedge clk);
        checkOutput("both_single", done_cnt[1], d1 + 1);

        // back-to-back rx words
        $display("[TB] back to back");
        d0 = done_cnt[0];
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        applyStimulus(0, w1, 1'b1, 1'b0);
        applyStimulus(0, w2, 1'b1, 1'b0);
        wait_done(0, d0 + 2, 300);
        checkOutput("b2b_first", prev_mosi[0], w1);
        checkOutput("b2b_second", last_mosi[0], w2);
        checkOutput("b2b_gap_min", last_gap[0] >= 4, 1);
        wait_idle(0);

        // reset in the middle of a transfer
        $display("[TB] reset mid transfer");
        applyStimulus(0, 16'($urandom), 1'b1, 1'b0);
        n = 0;
        while (rise_cnt[0] < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reached_rise7", rise_cnt[0] >= 7, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_ss", ss_w[0], 1);
        checkOutput("abort_sck", sck_w[0], 0);
        checkOutput("abort_mosi", mosi_w[0], 1);
        checkOutput("abort_rx_accept", rx_accept_w[0], 0);
        checkOutput("abort_tx_strobe", tx_strobe_w[0], 0);
        checkOutput("abort_busy", busy_w[0], 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        d0 = done_cnt[0];
        w1 = 16'($urandom);
        applyStimulus(0, w1, 1'b1, 1'b0);
        wait_done(0, d0 + 1, 200);
        checkOutput("post_reset_mosi", last_mosi[0], w1);
        checkOutput("post_reset_low", last_low[0], 32);
        checkOutput("post_reset_rises", last_rises[0], 16);
        wait_idle(0);

`ifdef SPIM_RX_SKID_EN
        // second word accepted into the holding buffer mid-transfer
        $display("[TB] skid buffer");
        d0 = done_cnt[0];
        w1 = 16'($urandom);
        applyStimulus(0, w1, 1'b1, 1'b0);
        n = 0;
        while (rise_cnt[0] < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rx_data_w[0]   = 16'h00FF;
        rx_strobe_w[0] = 1'b1;
        @(negedge clk);
        checkOutput("skid_accept", rx_accept_w[0], 1);
        rx_strobe_w[0] = 1'b0;
        wait_done(0, d0 + 2, 300);
        checkOutput("skid_first", prev_mosi[0], w1);
        checkOutput("skid_second", last_mosi[0], 16'h00FF);
        wait_idle(0);
`endif

        // randomized transfers on both instances
        $display("[TB] random transfers");
        for (int k = 0; k < 12; k++) begin
            inst = $urandom_range(0, 1);
            mode = $urandom_range(0, 2);
            rw   = 16'($urandom);
            mw   = 16'($urandom);
            d0   = done_cnt[inst];
            slave_word[inst] = mw;
            applyStimulus(inst, rw, mode != 1, mode != 0);
            wait_done(inst, d0 + 1, 400);
            checkOutput("rnd_mosi", last_mosi[inst], (mode != 1) ? rw : 16'hFFFF);
            checkOutput("rnd_tx_strobe", last_txs[inst], mode != 0);
            if (mode != 0) checkOutput("rnd_tx_data", last_txd[inst], mw);
            checkOutput("rnd_ss_low", last_low[inst], 2 * div_of(inst) * W);
            tx_request_w[inst] = 1'b0;
            wait_idle(inst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
